// File: rtl/adsr_engine.sv
// adsr_engine: multi-voice ADSR envelope generator with a serial amplitude
// multiplier. A request updates one voice's envelope (state + 24-bit Q8.16
// volume), then scales the supplied wave sample by the new 8-bit level using
// an 8-cycle shift-add, and pulses done_o when the enveloped sample is ready.
//
// Handshake: a request is accepted on a rising clk_i edge where the block is
// idle, start_i=1 and voice_idx_i < NUM_VOICES. busy_o is high from the cycle
// after acceptance until the done cycle inclusive. Voice inputs (gate, wave,
// ADSR settings, hard restart) are sampled in the single cycle after
// acceptance and may change afterwards. done_o is a one-cycle pulse; wave_o
// is valid from that cycle and held until the next done_o.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, voice_idx_i     request and addressed voice
//   wave_i                   raw unsigned wave sample
//   gate_i, hard_restart_i   gate of the voice, restart-from-zero on gate-on
//   attack_i .. release_i    4-bit ADSR settings
//   busy_o, done_o           request in progress / completion pulse
//   wave_o                   enveloped sample
//   env_o, state_o           level and ADSR state of the last processed voice
module adsr_engine #(
  parameter int NUM_VOICES = 3,
  parameter int WAVE_W     = 10,
  localparam int IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [IDX_W-1:0]  voice_idx_i,
  input  logic [WAVE_W-1:0] wave_i,
  input  logic              gate_i,
  input  logic              hard_restart_i,
  input  logic [3:0]        attack_i,
  input  logic [3:0]        decay_i,
  input  logic [3:0]        sustain_i,
  input  logic [3:0]        release_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WAVE_W-1:0] wave_o,
  output logic [7:0]        env_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_MULT, S_DONE} fsm_e;

  localparam logic [1:0]  V_ATTACK  = 2'd0;
  localparam logic [1:0]  V_DECAY   = 2'd1;
  localparam logic [1:0]  V_SUSTAIN = 2'd2;
  localparam logic [1:0]  V_RELEASE = 2'd3;
  localparam logic [23:0] VOL_MAX   = 24'hFFFFFF;

  fsm_e                  state_q, state_d;
  logic                  accept;
  logic [IDX_W-1:0]      idx_q;
  logic [23:0]           vol_q [NUM_VOICES];
  logic [1:0]            vst_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_prev_q;
  logic [2:0]            cnt_q;
  logic [WAVE_W+7:0]     mcand_q, acc_q, acc_d;
  logic [7:0]            mplier_q;
  logic [WAVE_W-1:0]     wave_q;
  logic [7:0]            env_q;
  logic [1:0]            st_out_q;

  logic [23:0] cur_vol, vol_eff, sus_vol, vol_d;
  logic [1:0]  cur_st, vst_d;
  logic        rising;
  logic [1:0]  sh;
  logic [17:0] att_step, dec_step, rel_step;
  logic [24:0] att_sum, dec_floor;

  function automatic logic [17:0] attack_tab(input logic [3:0] i);
    case (i)
      4'h0: attack_tab = 18'd167116;
      4'h1: attack_tab = 18'd41779;
      4'h2: attack_tab = 18'd20889;
      4'h3: attack_tab = 18'd13926;
      4'h4: attack_tab = 18'd8795;
      4'h5: attack_tab = 18'd5968;
      4'h6: attack_tab = 18'd4915;
      4'h7: attack_tab = 18'd4177;
      4'h8: attack_tab = 18'd3342;
      4'h9: attack_tab = 18'd1336;
      4'hA: attack_tab = 18'd668;
      4'hB: attack_tab = 18'd417;
      4'hC: attack_tab = 18'd334;
      4'hD: attack_tab = 18'd111;
      4'hE: attack_tab = 18'd66;
      default: attack_tab = 18'd41;
    endcase
  endfunction

  function automatic logic [17:0] dr_base_tab(input logic [3:0] i);
    case (i)
      4'h0: dr_base_tab = 18'd139262;
      4'h1: dr_base_tab = 18'd34815;
      4'h2: dr_base_tab = 18'd17407;
      4'h3: dr_base_tab = 18'd11605;
      4'h4: dr_base_tab = 18'd7327;
      4'h5: dr_base_tab = 18'd4972;
      4'h6: dr_base_tab = 18'd4095;
      4'h7: dr_base_tab = 18'd3480;
      4'h8: dr_base_tab = 18'd2785;
      4'h9: dr_base_tab = 18'd1112;
      4'hA: dr_base_tab = 18'd555;
      4'hB: dr_base_tab = 18'd347;
      4'hC: dr_base_tab = 18'd277;
      4'hD: dr_base_tab = 18'd92;
      4'hE: dr_base_tab = 18'd55;
      default: dr_base_tab = 18'd32;
    endcase
  endfunction

  // Master FSM next state.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && (int'(voice_idx_i) < NUM_VOICES)) begin
          accept  = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_MULT;
      S_MULT:   if (cnt_q == 3'd7) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Envelope step for the addressed voice; only committed in S_UPDATE.
  always_comb begin
    cur_vol = vol_q[idx_q];
    cur_st  = vst_q[idx_q];
    rising  = gate_i & ~gate_prev_q[idx_q];
    // sustain_i * 0x11 is the nibble duplicated into a byte.
    sus_vol = {sustain_i, sustain_i, 16'h0000};
    vol_eff = (rising && hard_restart_i) ? 24'h000000 : cur_vol;

    // Exponential-ish decay: smaller steps as the level falls.
    if (cur_vol[23])      sh = 2'd0;
    else if (cur_vol[22]) sh = 2'd1;
    else if (cur_vol[21]) sh = 2'd2;
    else                  sh = 2'd3;

    att_step  = attack_tab(attack_i);
    dec_step  = (dr_base_tab(decay_i) >> sh) | 18'd1;
    rel_step  = (dr_base_tab(release_i) >> sh) | 18'd1;
    att_sum   = {1'b0, vol_eff} + {7'b0, att_step};
    // 25 bits: sustain level plus step can exceed the 24-bit range.
    dec_floor = {1'b0, sus_vol} + {7'b0, dec_step};

    if (!gate_i)                                        vst_d = V_RELEASE;
    else if (rising)                                    vst_d = V_ATTACK;
    else if (cur_st == V_ATTACK && cur_vol == VOL_MAX)  vst_d = V_DECAY;
    else if (cur_st == V_DECAY && cur_vol <= sus_vol)   vst_d = V_SUSTAIN;
    else                                                vst_d = cur_st;

    case (vst_d)
      V_ATTACK:  vol_d = att_sum[24] ? VOL_MAX : att_sum[23:0];
      V_DECAY:   vol_d = ({1'b0, cur_vol} <= dec_floor) ? sus_vol
                                                         : cur_vol - {6'b0, dec_step};
      V_SUSTAIN: vol_d = sus_vol;
      default:   vol_d = (cur_vol <= {6'b0, rel_step}) ? 24'h000000
                                                        : cur_vol - {6'b0, rel_step};
    endcase
  end

  // One multiplier bit per MULT cycle, LSB first.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      wave_q      <= '0;
      env_q       <= '0;
      st_out_q    <= V_RELEASE;
      gate_prev_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vol_q[v] <= '0;
        vst_q[v] <= V_RELEASE;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (accept) idx_q <= voice_idx_i;
        S_UPDATE: begin
          vol_q[idx_q]       <= vol_d;
          vst_q[idx_q]       <= vst_d;
          gate_prev_q[idx_q] <= gate_i;
          env_q              <= vol_d[23:16];
          st_out_q           <= vst_d;
          mcand_q            <= {8'h00, wave_i};
          mplier_q           <= vol_d[23:16];
          acc_q              <= '0;
          cnt_q              <= '0;
        end
        S_MULT: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 3'd1;
          // Final product lands in wave_q as the FSM enters S_DONE.
          if (cnt_q == 3'd7) wave_q <= acc_d[WAVE_W+7:8];
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE);
  assign wave_o  = wave_q;
  assign env_o   = env_q;
  assign state_o = st_out_q;

endmodule

// File: tb/tb_adsr_engine.sv
// Testbench for adsr_engine: directed envelope scenarios plus randomized
// requests, checked against an arithmetic envelope model with an expected
// result queue.
module tb_adsr_engine;
  localparam int NV   = 3;
  localparam int WW   = 10;
  localparam int MAXV = 16777215;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [1:0]    voice_idx_i;
  logic [WW-1:0] wave_i;
  logic          gate_i, hard_restart_i;
  logic [3:0]    attack_i, decay_i, sustain_i, release_i;
  logic          busy_o, done_o;
  logic [WW-1:0] wave_o;
  logic [7:0]    env_o;
  logic [1:0]    state_o;

  adsr_engine #(.NUM_VOICES(NV), .WAVE_W(WW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .voice_idx_i(voice_idx_i),
    .wave_i(wave_i), .gate_i(gate_i), .hard_restart_i(hard_restart_i),
    .attack_i(attack_i), .decay_i(decay_i), .sustain_i(sustain_i),
    .release_i(release_i), .busy_o(busy_o), .done_o(done_o), .wave_o(wave_o),
    .env_o(env_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [19:0] exp_q[$];  // {state[1:0], level[7:0], wave[9:0]}
  logic [7:0]    cap_env;
  logic [1:0]    cap_st;
  logic [WW-1:0] cap_wave;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_vol[NV];
  int m_st[NV];
  int m_gp[NV];
  int atab[16] = '{167116, 41779, 20889, 13926, 8795, 5968, 4915, 4177,
                   3342, 1336, 668, 417, 334, 111, 66, 41};
  int dtab[16] = '{139262, 34815, 17407, 11605, 7327, 4972, 4095, 3480,
                   2785, 1112, 555, 347, 277, 92, 55, 32};

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_vol[v] = 0;
      m_st[v]  = 3;
      m_gp[v]  = 0;
    end
  endtask

  task automatic model_step(input int v, input int g, input int hr, input int a,
                            input int d, input int s, input int r, input int wv);
    int vol, st, sus, ns, sh, step, lvl, w;
    logic [1:0] ns2;
    logic [7:0] l8;
    logic [9:0] w10;
    vol = m_vol[v];
    st  = m_st[v];
    sus = s * 17 * 65536;
    if (vol >= (1 << 23))      sh = 0;
    else if (vol >= (1 << 22)) sh = 1;
    else if (vol >= (1 << 21)) sh = 2;
    else                       sh = 3;
    if (g == 0)                       ns = 3;
    else if (m_gp[v] == 0)            ns = 0;
    else if (st == 0 && vol == MAXV)  ns = 1;
    else if (st == 1 && vol <= sus)   ns = 2;
    else                              ns = st;
    case (ns)
      0: begin
        if (g != 0 && m_gp[v] == 0 && hr != 0) vol = 0;
        vol = vol + atab[a];
        if (vol > MAXV) vol = MAXV;
      end
      1: begin
        step = (dtab[d] >> sh) | 1;
        vol  = (vol <= sus + step) ? sus : vol - step;
      end
      2: vol = sus;
      default: begin
        step = (dtab[r] >> sh) | 1;
        vol  = (vol <= step) ? 0 : vol - step;
      end
    endcase
    m_vol[v] = vol;
    m_st[v]  = ns;
    m_gp[v]  = g;
    lvl = vol / 65536;
    w   = (wv * lvl) / 256;
    ns2 = ns[1:0];
    l8  = lvl[7:0];
    w10 = w[9:0];
    exp_q.push_back({ns2, l8, w10});
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input int v, input int g, input int hr, input int a, input int d,
                        input int s, input int r, input int wv, input bit junk);
    logic [19:0] e;
    int ndone, done_k;
    @(negedge clk_i);
    voice_idx_i    = v[1:0];
    gate_i         = g[0];
    hard_restart_i = hr[0];
    attack_i       = a[3:0];
    decay_i        = d[3:0];
    sustain_i      = s[3:0];
    release_i      = r[3:0];
    wave_i         = wv[WW-1:0];
    start_i        = 1'b1;
    model_step(v, g, hr, a, d, s, r, wv);
    ndone  = 0;
    done_k = -1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk_i);
      if (k == 0) begin
        start_i = 1'b0;
        check("busy_update", busy_o, 1);
      end
      if (k == 1) begin
        // Inputs were consumed in the update cycle; disturb them now.
        gate_i   = $urandom_range(0, 1);
        wave_i   = $urandom_range(0, 1023);
        attack_i = $urandom_range(0, 15);
        decay_i  = $urandom_range(0, 15);
      end
      if (junk && k >= 3 && k <= 5) begin
        start_i     = 1'b1;
        voice_idx_i = $urandom_range(0, 3);
      end
      if (junk && k == 6) start_i = 1'b0;
      if (done_o === 1'b1) begin
        ndone++;
        done_k   = k;
        cap_env  = env_o;
        cap_st   = state_o;
        cap_wave = wave_o;
      end
      if (k == 10) check("busy_idle", busy_o, 0);
    end
    check("done_count", ndone, 1);
    check("done_latency", done_k, 9);
    e = exp_q.pop_front();
    check("state_o", cap_st, e[19:18]);
    check("env_o", cap_env, e[17:10]);
    check("wave_o", cap_wave, e[9:0]);
    check("wave_hold", wave_o, e[9:0]);
  endtask

  task automatic bad_idx_req();
    int nd, nb;
    nd = 0;
    nb = 0;
    @(negedge clk_i);
    voice_idx_i = 2'd3;
    gate_i      = 1'b1;
    attack_i    = 4'h0;
    start_i     = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o === 1'b1) nd++;
      if (busy_o !== 1'b0) nb++;
    end
    check("bad_idx_done", nd, 0);
    check("bad_idx_busy", nb, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int reached, nd;
    rst_ni = 1'b0;
    start_i = 1'b0;
    voice_idx_i = '0;
    wave_i = '0;
    gate_i = 1'b0;
    hard_restart_i = 1'b0;
    attack_i = '0;
    decay_i = '0;
    sustain_i = '0;
    release_i = '0;
    model_reset();
    repeat (3) @(negedge clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_wave", wave_o, 0);
    check("rst_env", env_o, 0);
    check("rst_state", state_o, 3);
    rst_ni = 1'b1;

    // Voice 0: fastest attack to full scale, then first decay step.
    do_req(0, 1, 0, 0, 0, 0, 0, 1023, 0);
    check("v0_first_state", cap_st, 0);
    check("v0_first_env", cap_env, 8'h02);
    check("v0_first_wave", cap_wave, 7);
    for (int i = 2; i <= 102; i++) begin
      do_req(0, 1, 0, 0, 0, 0, 0, 1023, 0);
      if (i == 101) check("v0_full_env", cap_env, 8'hFF);
    end
    check("v0_decay_state", cap_st, 1);
    check("v0_decay_env", cap_env, 8'hFD);

    // Voice 1: reach sustain 0x88, then release.
    reached = 0;
    for (int i = 0; i < 300 && reached == 0; i++) begin
      do_req(1, 1, 0, 0, 0, 8, 0, $urandom_range(0, 1023), 0);
      if (cap_st == 2'd2 && cap_env == 8'h88) reached = 1;
    end
    check("v1_sustain_reached", reached, 1);
    do_req(1, 0, 0, 0, 0, 8, 0, $urandom_range(0, 1023), 0);
    check("v1_release_state", cap_st, 3);
    check("v1_release_env", cap_env, 8'h85);

    // Voice 2: sustain 0x44, release to 0x40, gate-on without/with hard restart.
    reached = 0;
    for (int i = 0; i < 400 && reached == 0; i++) begin
      do_req(2, 1, 0, 0, 0, 4, 0, $urandom_range(0, 1023), 0);
      if (cap_st == 2'd2) reached = 1;
    end
    check("v2_sustain_reached", reached, 1);
    for (int pass = 0; pass < 2; pass++) begin
      reached = 0;
      for (int i = 0; i < 200 && reached == 0; i++) begin
        do_req(2, 0, 0, 0, 0, 4, 4, $urandom_range(0, 1023), 0);
        if (cap_env <= 8'h40) reached = 1;
      end
      check("v2_release_reached", reached, 1);
      do_req(2, 1, pass, 0, 0, 4, 4, 1023, 0);
      check("v2_gate_on_state", cap_st, 0);
      if (pass == 1) check("v2_hard_restart_env", cap_env, 8'h02);
    end

    // Starts during MULT and an out-of-range voice are ignored.
    do_req(1, 1, 0, 3, 5, 6, 7, 512, 1);
    bad_idx_req();
    for (int v = 0; v < NV; v++) do_req(v, 1, 0, 2, 2, 2, 2, $urandom_range(0, 1023), 0);

    // Reset in the middle of a request.
    @(negedge clk_i);
    voice_idx_i = 2'd0;
    gate_i      = 1'b1;
    attack_i    = 4'h0;
    wave_i      = 10'h3FF;
    start_i     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
    end
    rst_ni = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_env", env_o, 0);
    check("midrst_state", state_o, 3);
    check("midrst_wave", wave_o, 0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) nd++;
    end
    check("midrst_no_done", nd, 0);
    do_req(0, 1, 0, 0, 0, 0, 0, 1023, 0);
    check("post_rst_env", cap_env, 8'h02);

    // Randomized requests.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) bad_idx_req();
      else
        do_req($urandom_range(0, NV - 1), ($urandom_range(0, 3) != 0) ? 1 : 0,
               $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1023),
               ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
